// File: rtl/alu_sequencer.sv
// Microsequencer that runs a program from internal RAM and feeds the ALU/register
// datapath, resolving jumps and halts locally and latching ALU flags after each op.
module alu_sequencer #(
    parameter int                PC_W     = 6,
    parameter int                DATA_W   = 16,
    parameter int                FLAG_LAT = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'hC000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [PC_W-1:0]       prog_addr,
    input  logic [2*DATA_W-1:0]   prog_wdata,
    input  logic                  start,
    input  logic [3:0]            alu_flags,
    output logic [DATA_W-1:0]     dp_operator,
    output logic [DATA_W-1:0]     dp_operand,
    output logic                  dp_valid,
    output logic                  busy,
    output logic                  done,
    output logic [PC_W-1:0]       pc,
    output logic [3:0]            flags_q
);

    localparam int DEPTH   = 2 ** PC_W;
    localparam int INSTR_W = 2 * DATA_W;
    localparam int CNT_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        SETTLE,
        HALT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [INSTR_W-1:0]  mem [DEPTH];
    logic [INSTR_W-1:0]  instr;
    logic [DATA_W-1:0]   operand_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [3:0]          opcode;
    logic [3:0]          cond_mask;
    logic [PC_W-1:0]     jump_target;
    logic [PC_W-1:0]     pc_inc;
    logic                cond_taken;

    assign opcode      = instr[INSTR_W-1 -: 4];
    assign cond_mask   = instr[DATA_W+3:DATA_W];
    assign jump_target = instr[PC_W-1:0];
    assign pc_inc      = pc + PC_W'(1);
    assign cond_taken  = |(flags_q & cond_mask);

    // Program RAM has no reset; the read port gives the instruction one cycle after FETCH.
    always_ff @(posedge clk) begin
        if (prog_we && state == IDLE)
            mem[prog_addr] <= prog_wdata;
        if (state == FETCH)
            instr <= mem[pc];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        dp_valid    = 1'b0;
        dp_operator = NOP_WORD;
        dp_operand  = operand_q;
        case (state)
            IDLE: begin
                if (start)
                    state_next = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                busy = 1'b1;
                case (opcode)
                    4'hF:    state_next = HALT;
                    4'hD:    state_next = FETCH;
                    4'hE:    state_next = FETCH;
                    default: state_next = ISSUE;
                endcase
            end
            ISSUE: begin
                busy        = 1'b1;
                dp_valid    = 1'b1;
                dp_operator = instr[INSTR_W-1:DATA_W];
                dp_operand  = instr[DATA_W-1:0];
                state_next  = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (wait_cnt == CNT_W'(1))
                    state_next = FETCH;
            end
            HALT: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // pc wraps naturally at 2**PC_W; the operand register keeps the bus stable between issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            wait_cnt  <= '0;
            flags_q   <= '0;
            operand_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        pc <= '0;
                end
                DECODE: begin
                    if (opcode == 4'hD)
                        pc <= jump_target;
                    else if (opcode == 4'hE)
                        pc <= cond_taken ? jump_target : pc_inc;
                end
                ISSUE: begin
                    wait_cnt  <= CNT_W'(FLAG_LAT);
                    operand_q <= instr[DATA_W-1:0];
                end
                SETTLE: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        flags_q <= alu_flags;
                        pc      <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a FLAG_LAT=1 instance for most scenarios and a
// FLAG_LAT=3 instance sharing the same inputs for the flag-latency scenario.
module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic        start;
    logic [3:0]  alu_flags;

    logic [15:0] dp_operator, dp_operand;
    logic        dp_valid, busy, done;
    logic [5:0]  pc;
    logic [3:0]  flags_q;

    logic [15:0] dp_operator_3, dp_operand_3;
    logic        dp_valid_3, busy_3, done_3;
    logic [5:0]  pc_3;
    logic [3:0]  flags_q_3;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [5:0]  exp_pc_q[$];

    alu_sequencer #(.PC_W(6), .DATA_W(16), .FLAG_LAT(1), .NOP_WORD(16'hC000)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .alu_flags(alu_flags),
        .dp_operator(dp_operator), .dp_operand(dp_operand), .dp_valid(dp_valid),
        .busy(busy), .done(done), .pc(pc), .flags_q(flags_q)
    );

    alu_sequencer #(.PC_W(6), .DATA_W(16), .FLAG_LAT(3), .NOP_WORD(16'hC000)) dut_3 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .alu_flags(alu_flags),
        .dp_operator(dp_operator_3), .dp_operand(dp_operand_3), .dp_valid(dp_valid_3),
        .busy(busy_3), .done(done_3), .pc(pc_3), .flags_q(flags_q_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [5:0] a, input logic [31:0] w);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = w;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (dp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dp_valid: got %b expected 0", dp_valid); end
        checks++; if (dp_operator !== 16'hC000) begin errors++; $display("[TB] FAIL reset_dp_operator: got %h expected c000", dp_operator); end
        checks++; if (dp_operand !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dp_operand: got %h expected 0000", dp_operand); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        checks++; if (pc !== 6'd0) begin errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", pc); end
        checks++; if (flags_q !== 4'h0) begin errors++; $display("[TB] FAIL reset_flags_q: got %h expected 0", flags_q); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int nvalid = 0;
        int ndone = 0;
        int done_cyc = -1;
        logic [5:0] pc_at_done = '0;
        logic [31:0] w;
        exp_q.delete();
        load_word(6'd0, {16'h0003, 16'h0201});
        load_word(6'd1, 32'hF000_0000);
        alu_flags = 4'b0101;
        exp_q.push_back({16'h0003, 16'h0201});
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise: got %b expected 1", busy); end
        for (int c = 1; c <= 15; c++) begin
            if (dp_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL basic_issue: got %h%h expected no issue", dp_operator, dp_operand);
                end else begin
                    w = exp_q.pop_front();
                    if ({dp_operator, dp_operand} !== w) begin errors++; $display("[TB] FAIL basic_issue: got %h%h expected %h", dp_operator, dp_operand, w); end
                end
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = c;
                pc_at_done = pc;
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy); end
            end
            tick();
        end
        checks++; if (nvalid != 1) begin errors++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", nvalid); end
        checks++; if (ndone != 1 || done_cyc != 7) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d (count %0d) expected 7", done_cyc, ndone); end
        checks++; if (pc_at_done !== 6'd1) begin errors++; $display("[TB] FAIL basic_pc_at_done: got %0d expected 1", pc_at_done); end
        checks++; if (flags_q !== 4'b0101) begin errors++; $display("[TB] FAIL basic_flags_q: got %b expected 0101", flags_q); end
        checks++; if (dp_operand !== 16'h0201 || dp_operator !== 16'hC000) begin errors++; $display("[TB] FAIL basic_idle_bus: got %h/%h expected c000/0201", dp_operator, dp_operand); end
    endtask

    task automatic test_jcond(input logic [3:0] flags_in, input logic [5:0] exp_pc, input string name);
        int nvalid = 0;
        int done_cyc = -1;
        logic [5:0] pc_at_done = '0;
        logic [31:0] w;
        exp_q.delete();
        load_word(6'd0, {16'h0001, 16'h0000});
        load_word(6'd1, {16'hE001, 16'h0005});
        load_word(6'd2, 32'hF000_0000);
        load_word(6'd5, 32'hF000_0000);
        alu_flags = flags_in;
        exp_q.push_back({16'h0001, 16'h0000});
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (dp_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL %s_issue: got %h%h expected no issue", name, dp_operator, dp_operand);
                end else begin
                    w = exp_q.pop_front();
                    if ({dp_operator, dp_operand} !== w) begin errors++; $display("[TB] FAIL %s_issue: got %h%h expected %h", name, dp_operator, dp_operand, w); end
                end
            end
            if (done === 1'b1) begin
                done_cyc = c;
                pc_at_done = pc;
            end
            tick();
        end
        checks++; if (done_cyc != 9) begin errors++; $display("[TB] FAIL %s_done_cycle: got %0d expected 9", name, done_cyc); end
        checks++; if (pc_at_done !== exp_pc) begin errors++; $display("[TB] FAIL %s_pc: got %0d expected %0d", name, pc_at_done, exp_pc); end
        checks++; if (flags_q !== flags_in || nvalid != 1) begin errors++; $display("[TB] FAIL %s_flags: got %b/%0d expected %b/1", name, flags_q, nvalid, flags_in); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] w;
        for (int run = 0; run < 2; run++) begin
            int nvalid = 0;
            int ndone = 0;
            int done_cyc = -1;
            exp_q.delete();
            if (run == 0) begin
                load_word(6'd0, {16'h0011, 16'h0AAA});
                load_word(6'd1, {16'h0022, 16'h0BBB});
                load_word(6'd2, 32'hF000_0000);
            end
            exp_q.push_back({16'h0011, 16'h0AAA});
            exp_q.push_back({16'h0022, 16'h0BBB});
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 25; c++) begin
                if (run == 0 && c == 2) begin
                    prog_we = 1'b1; prog_addr = 6'd1; prog_wdata = {16'h0033, 16'h0CCC}; start = 1'b1;
                end else begin
                    prog_we = 1'b0; start = 1'b0;
                end
                if (dp_valid === 1'b1) begin
                    nvalid++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("[TB] FAIL busy_ignore_issue: got %h%h expected no issue", dp_operator, dp_operand);
                    end else begin
                        w = exp_q.pop_front();
                        if ({dp_operator, dp_operand} !== w) begin errors++; $display("[TB] FAIL busy_ignore_issue: got %h%h expected %h", dp_operator, dp_operand, w); end
                    end
                end
                if (done === 1'b1) begin
                    ndone++;
                    if (done_cyc < 0) done_cyc = c;
                end
                tick();
            end
            prog_we = 1'b0;
            start = 1'b0;
            checks++; if (nvalid != 2) begin errors++; $display("[TB] FAIL busy_ignore_valid_count: got %0d expected 2", nvalid); end
            checks++; if (ndone != 1 || done_cyc != 11) begin errors++; $display("[TB] FAIL busy_ignore_done: got cycle %0d count %0d expected 11/1", done_cyc, ndone); end
        end
    endtask

    task automatic test_we_with_start();
        int nvalid = 0;
        int done_cyc = -1;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back({16'h0044, 16'h0DDD});
        exp_q.push_back({16'h0022, 16'h0BBB});
        prog_we = 1'b1; prog_addr = 6'd0; prog_wdata = {16'h0044, 16'h0DDD}; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (dp_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL we_start_issue: got %h%h expected no issue", dp_operator, dp_operand);
                end else begin
                    w = exp_q.pop_front();
                    if ({dp_operator, dp_operand} !== w) begin errors++; $display("[TB] FAIL we_start_issue: got %h%h expected %h", dp_operator, dp_operand, w); end
                end
            end
            if (done === 1'b1) done_cyc = c;
            tick();
        end
        checks++; if (nvalid != 2 || done_cyc != 11) begin errors++; $display("[TB] FAIL we_start_done: got valid %0d done %0d expected 2/11", nvalid, done_cyc); end
    endtask

    task automatic test_wrap_and_reset();
        int nwrap = 0;
        bit reset_done = 0;
        logic [5:0] last_pc;
        logic [5:0] epc;
        logic [31:0] w;
        exp_q.delete();
        exp_pc_q.delete();
        load_word(6'd0, {16'hD000, 16'h003E});
        load_word(6'd62, {16'hC000, 16'h0062});
        load_word(6'd63, {16'h0007, 16'h0063});
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({16'hC000, 16'h0062}); exp_pc_q.push_back(6'd62);
            exp_q.push_back({16'h0007, 16'h0063}); exp_pc_q.push_back(6'd63);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        last_pc = pc;
        for (int c = 1; c <= 60 && !reset_done; c++) begin
            if (last_pc == 6'd63 && pc != 6'd63) begin
                nwrap++;
                checks++; if (pc !== 6'd0) begin errors++; $display("[TB] FAIL wrap_pc: got %0d expected 0", pc); end
            end
            last_pc = pc;
            if (dp_valid === 1'b1 && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                epc = exp_pc_q.pop_front();
                checks++; if ({dp_operator, dp_operand} !== w) begin errors++; $display("[TB] FAIL wrap_issue: got %h%h expected %h", dp_operator, dp_operand, w); end
                checks++; if (pc !== epc) begin errors++; $display("[TB] FAIL wrap_issue_pc: got %0d expected %0d", pc, epc); end
                if (exp_q.size() == 0) begin
                    #2;
                    reset = 1'b1;
                    #1;
                    reset_done = 1;
                    checks++; if (dp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid_busy: got %b%b expected 00", dp_valid, busy); end
                    checks++; if (pc !== 6'd0 || flags_q !== 4'h0) begin errors++; $display("[TB] FAIL async_reset_pc_flags: got %0d/%h expected 0/0", pc, flags_q); end
                    checks++; if (dp_operator !== 16'hC000 || dp_operand !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset_bus: got %h/%h expected c000/0000", dp_operator, dp_operand); end
                end
            end
            if (!reset_done) tick();
        end
        checks++; if (!reset_done) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d issues left expected 0", exp_q.size()); end
        checks++; if (nwrap < 1) begin errors++; $display("[TB] FAIL wrap_seen: got %0d wraps expected at least 1", nwrap); end
        tick();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0 || pc !== 6'd0) begin errors++; $display("[TB] FAIL post_reset_idle: got busy %b pc %0d expected 0/0", busy, pc); end
    endtask

    task automatic test_flag_lat3();
        int issue_q[$];
        int due_q[$];
        logic [3:0] flag_q[$];
        int ndone = 0;
        int done_cyc = -1;
        int ic;
        logic [3:0] f;
        logic [31:0] w;
        exp_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        load_word(6'd0, {16'h0005, 16'h0001});
        load_word(6'd1, {16'h0006, 16'h0002});
        load_word(6'd2, 32'hF000_0000);
        exp_q.push_back({16'h0005, 16'h0001}); issue_q.push_back(3);
        exp_q.push_back({16'h0006, 16'h0002}); issue_q.push_back(9);
        alu_flags = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            alu_flags = 4'(c);
            if (due_q.size() > 0 && due_q[0] == c) begin
                void'(due_q.pop_front());
                f = flag_q.pop_front();
                checks++; if (flags_q_3 !== f) begin errors++; $display("[TB] FAIL lat3_flags_q: got %h expected %h at cycle %0d", flags_q_3, f, c); end
            end
            if (dp_valid_3 === 1'b1) begin
                checks++;
                if (issue_q.size() == 0) begin
                    errors++; $display("[TB] FAIL lat3_issue: got issue at cycle %0d expected none", c);
                end else begin
                    ic = issue_q.pop_front();
                    w = exp_q.pop_front();
                    if (c != ic || {dp_operator_3, dp_operand_3} !== w) begin errors++; $display("[TB] FAIL lat3_issue: got %h%h at %0d expected %h at %0d", dp_operator_3, dp_operand_3, c, w, ic); end
                end
                flag_q.push_back(4'(c + 3));
                due_q.push_back(c + 4);
            end
            if (done_3 === 1'b1) begin
                ndone++;
                done_cyc = c;
            end
            tick();
        end
        checks++; if (ndone != 1 || done_cyc != 15) begin errors++; $display("[TB] FAIL lat3_done: got cycle %0d count %0d expected 15/1", done_cyc, ndone); end
        checks++; if (issue_q.size() != 0 || due_q.size() != 0) begin errors++; $display("[TB] FAIL lat3_pending: got %0d/%0d pending expected 0/0", issue_q.size(), due_q.size()); end
    endtask

    initial begin
        reset      = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        start      = 1'b0;
        alu_flags  = '0;
        test_reset();
        test_basic();
        test_jcond(4'b0001, 6'd5, "jcond_taken");
        test_jcond(4'b1110, 6'd2, "jcond_not_taken");
        test_busy_ignore();
        test_we_with_start();
        test_wrap_and_reset();
        test_flag_lat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Small microsequencer that drives the ALU/register datapath.
- Holds a program of 32-bit instruction words {operator, operand} in an internal synchronous RAM that is loaded over a write port.
- On start, executes the program from address 0: issues datapath words one per instruction, latches ALU flags, and resolves jump and halt instructions locally.
- Sits between the top-level control/host interface and the alu_register datapath's operator/operand/alu_flags ports.

Parameters:
- PC_W, 6, program address width; depth = 2**PC_W words.
- DATA_W, 16, width of operator and operand fields.
- FLAG_LAT, 1, cycles from issue until alu_flags reflects the issued op (1..3).
- NOP_WORD, 16'hC000, operator value driven when no instruction is issued; opcode 4'hC is a datapath no-op.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- prog_we  in  1  program RAM write strobe; accepted only in IDLE
- prog_addr  in  PC_W  program RAM write address
- prog_wdata  in  2*DATA_W  instruction word, [31:16]=operator, [15:0]=operand
- start  in  1  single-cycle pulse; begin execution at PC 0
- alu_flags  in  4  flags from datapath
- dp_operator  out  DATA_W  operator to datapath
- dp_operand  out  DATA_W  operand to datapath
- dp_valid  out  1  high for exactly the issue cycle of a datapath instruction
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse on halt
- pc  out  PC_W  current program counter
- flags_q  out  4  last latched ALU flags

Behaviour:
- Reset values (asynchronous): state=IDLE, pc=0, dp_operator=NOP_WORD, dp_operand=0, dp_valid=0, busy=0, done=0, flags_q=0, wait counter=0. Program RAM contents are not reset.
- States: IDLE, FETCH, DECODE, ISSUE, SETTLE, HALT.
- IDLE:
  - prog_we writes RAM[prog_addr].
  - start moves to FETCH with pc=0.
  - prog_we outside IDLE is ignored. start outside IDLE is ignored.
  - If prog_we and start occur in the same cycle: the write completes, then execution starts.
- FETCH: synchronous RAM read of RAM[pc]. The instruction register is valid in DECODE (1-cycle read latency).
- DECODE: on opcode = instr[31:28]:
  - 4'hF HALT: go to HALT.
  - 4'hD JMP: pc <= instr[PC_W-1:0]; go to FETCH.
  - 4'hE JCOND: if (flags_q & instr[19:16]) != 0, pc <= instr[PC_W-1:0], else pc <= pc+1; go to FETCH.
  - Any other opcode: go to ISSUE.
- ISSUE (1 cycle):
  - dp_operator = instr[31:16], dp_operand = instr[15:0], dp_valid = 1.
  - Load wait counter with FLAG_LAT; go to SETTLE.
- SETTLE:
  - dp_operator returns to NOP_WORD and dp_valid = 0. dp_operand holds its last value.
  - Decrement the counter. When it reaches 0, flags_q <= alu_flags, pc <= pc+1, go to FETCH.
- HALT: done = 1 for one cycle, busy drops in the same cycle, then go to IDLE. pc holds the halt address.
- pc arithmetic is modulo 2**PC_W: incrementing from all-ones wraps to 0 with no error.
- Throughput: one datapath instruction costs 3+FLAG_LAT cycles; a taken or untaken jump costs 2 cycles.
- An infinite loop is legal. Only reset leaves it.
- Reset asserted mid-program aborts immediately to the reset values. The datapath sees dp_valid=0 from the reset edge onward.
- Control opcodes (D/E/F) are never presented on dp_operator.

Test Plan:
- Load RAM[0]={16'h0003,16'h0201}, RAM[1]={16'hF000,0}; pulse start -> dp_valid high for exactly 1 cycle with dp_operator=16'h0003 and dp_operand=16'h0201; done pulses 7 cycles after start (FLAG_LAT=1); pc=1 at done.
- Program JCOND with mask 4'b0001; drive alu_flags=4'b0001 during SETTLE of the prior op -> pc jumps to the target; repeat with alu_flags=0 -> pc advances by 1.
- Place JMP at address 63 targeting 0, then fill the end of RAM with NOPs to check pc wraps 63->0 and execution continues; reset mid-run -> dp_valid=0, busy=0, pc=0 immediately and asynchronously.
- Pulse prog_we and start while busy -> RAM unchanged (verify by rerun) and no restart; prog_we with start in IDLE -> the written word executes.
- FLAG_LAT=3 build: each ALU instruction takes 6 cycles; flags_q equals alu_flags sampled exactly 3 cycles after the issue cycle.
